regfile_arbiter: RTL and testbench

- Shares the single-port SPI-style register file (rxtx0-3, ctrl, divider, ss at 0x00-0x18) between NUM_REQ requesters, e.g. CPU bus bridge and DMA/config engine.
- Arbitrates round-robin, checks the target address, sequences one register-file access at a time, and returns a per-requester response with read data.
- Sits directly in front of the register file and drives all of its command inputs.

---
 rtl/regfile_arbiter.sv | 99 +++++++++
 tb/tb_regfile_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin arbiter sequencing NUM_REQ requesters onto a single-port register file.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module regfile_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int REG_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR = 'h18
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [REG_WIDTH-1:0]          rsp_rdata,
    output logic                          rsp_err,
    output logic                          rf_regwrite,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    output logic [REG_WIDTH-1:0]          rf_write_data,
    input  logic [REG_WIDTH-1:0]          rf_read_data
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
    state_t                state;
    logic [IW-1:0]         ptr, win, idx;
    logic                  we, legal, cand_legal;
    logic [ADDR_WIDTH-1:0] cand_addr;
    int                    j;
    // Search downward so the requester nearest at/after the pointer is the last, winning, assignment.
    always_comb begin
        win = '0;
        j = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            win = req[IW'(j)] ? IW'(j) : win;
        end
        cand_addr = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        cand_legal = (cand_addr <= MAX_ADDR) && (cand_addr[1:0] == 2'b00);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt <= '0;
            rsp_valid <= '0;
            rsp_err <= 1'b0;
            rsp_rdata <= '0;
            rf_regwrite <= 1'b0;
            rf_addr <= '0;
            rf_write_data <= '0;
            ptr <= '0;
            idx <= '0;
            we <= 1'b0;
            legal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    idx <= win;
                    we <= req_we[win];
                    legal <= cand_legal;
                    gnt <= NUM_REQ'(1) << win;
                    rf_addr <= cand_addr;
                    rf_write_data <= req_wdata[win*REG_WIDTH +: REG_WIDTH];
                    rf_regwrite <= req_we[win] && cand_legal;
                    state <= ISSUE;
                end
                ISSUE: begin
                    gnt <= '0;
                    rf_regwrite <= 1'b0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
                    ptr <= '0;
`else
                    ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
`endif
                    if (!we && legal) begin
                        state <= CAPT;
                    end else begin
                        state <= RESP;
                        rsp_valid <= NUM_REQ'(1) << idx;
                        rsp_err <= !legal;
                        rsp_rdata <= legal ? rsp_rdata : '0;
                    end
                end
                CAPT: begin
                    rsp_rdata <= rf_read_data;
                    rsp_valid <= NUM_REQ'(1) << idx;
                    state <= RESP;
                end
                default: begin
                    rsp_valid <= '0;
                    rsp_err <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed tests of regfile_arbiter against a behavioural 7-entry register file.
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, req_we = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  gnt, rsp_valid;
    logic [31:0] rsp_rdata, rf_addr, rf_write_data, rf_read_data;
    logic        rsp_err, rf_regwrite;
    logic [31:0] mem [7];
    logic [31:0] sh [7];
    int          checks = 0, errors = 0;

    regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rf_regwrite(rf_regwrite), .rf_addr(rf_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, registered read of the presented address.
    always @(posedge clk) begin
        if (rf_regwrite && rf_addr[31:2] < 7) mem[rf_addr[4:2]] <= rf_write_data;
        rf_read_data <= (rf_addr[31:2] < 7) ? mem[rf_addr[4:2]] : 32'h0;
    end

    task automatic xfer(input int r, input logic w, input logic [31:0] a, d,
                        output int gc, output int rc, output logic [31:0] rd, output logic [31:0] ra,
                        output logic er, output logic rw, output logic [1:0] gv, output logic [1:0] rv);
        gc = -1; rc = -1; rd = '0; ra = '0; er = 1'b0; rw = 1'b0; gv = '0; rv = '0;
        @(negedge clk);
        req[r] = 1'b1; req_we[r] = w; req_addr[r*32 +: 32] = a; req_wdata[r*32 +: 32] = d;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rw |= rf_regwrite;
            if (gc < 0 && gnt != 0) begin gc = k; gv = gnt; ra = rf_addr; req[r] = 1'b0; end
            if (rsp_valid != 0) begin rc = k; rv = rsp_valid; rd = rsp_rdata; er = rsp_err; break; end
        end
        req[r] = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, rf_regwrite, rsp_rdata, rf_addr, rf_write_data} !== '0) begin
            errors++; $display("FAIL reset_outputs got gnt=%b rv=%b err=%b we=%b rd=%h a=%h wd=%h",
                gnt, rsp_valid, rsp_err, rf_regwrite, rsp_rdata, rf_addr, rf_write_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_wrap_all;
        int gc, rc; logic [31:0] rd, ra; logic er, rw; logic [1:0] gv, rv;
        for (int i = 0; i < 7; i++) begin
            sh[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
            xfer(i % 2, 1'b1, 32'(i * 4), sh[i], gc, rc, rd, ra, er, rw, gv, rv);
            checks++;
            if (rc !== 2 || er !== 1'b0 || rw !== 1'b1 || rv !== 2'(1 << (i % 2))) begin
                errors++; $display("FAIL wrap_write%0d got rc=%0d err=%b rw=%b rv=%b want rc=2 err=0 rw=1", i, rc, er, rw, rv);
            end
        end
        for (int i = 0; i < 7; i++) begin
            xfer(i % 2, 1'b0, 32'(i * 4), 32'h0, gc, rc, rd, ra, er, rw, gv, rv);
            checks++;
            if (rd !== sh[i] || rc !== 3 || er !== 1'b0) begin
                errors++; $display("FAIL wrap_read%0d got rd=%h rc=%0d err=%b want rd=%h rc=3", i, rd, rc, er, sh[i]);
            end
        end
    endtask

    task automatic test_single_write;
        int gc, rc; logic [31:0] rd, ra; logic er, rw; logic [1:0] gv, rv;
        xfer(0, 1'b1, 32'h10, 32'hA5A5_0001, gc, rc, rd, ra, er, rw, gv, rv);
        sh[4] = 32'hA5A5_0001;
        checks++;
        if (gc !== 1 || gv !== 2'b01 || ra !== 32'h10 || rw !== 1'b1) begin
            errors++; $display("FAIL write_gnt got gc=%0d gnt=%b addr=%h rw=%b want 1 01 10 1", gc, gv, ra, rw);
        end
        checks++;
        if (rc !== 2 || rv !== 2'b01 || er !== 1'b0) begin
            errors++; $display("FAIL write_rsp got rc=%0d rv=%b err=%b want 2 01 0", rc, rv, er);
        end
        xfer(1, 1'b0, 32'h10, 32'h0, gc, rc, rd, ra, er, rw, gv, rv);
        checks++;
        if (rd !== 32'hA5A5_0001) begin
            errors++; $display("FAIL write_readback got %h want a5a50001", rd);
        end
    endtask

    task automatic test_single_read;
        int gc, rc; logic [31:0] rd, ra; logic er, rw; logic [1:0] gv, rv;
        xfer(0, 1'b1, 32'h14, 32'h0000_0042, gc, rc, rd, ra, er, rw, gv, rv);
        sh[5] = 32'h42;
        xfer(1, 1'b0, 32'h14, 32'hFFFF_FFFF, gc, rc, rd, ra, er, rw, gv, rv);
        checks++;
        if (gc !== 1 || gv !== 2'b10 || rw !== 1'b0) begin
            errors++; $display("FAIL read_gnt got gc=%0d gnt=%b rw=%b want 1 10 0", gc, gv, rw);
        end
        checks++;
        if (rc !== 3 || rv !== 2'b10 || rd !== 32'h42 || er !== 1'b0) begin
            errors++; $display("FAIL read_rsp got rc=%0d rv=%b rd=%h err=%b want 3 10 42 0", rc, rv, rd, er);
        end
    endtask

    task automatic test_illegal;
        int gc, rc; logic [31:0] rd, ra; logic er, rw; logic [1:0] gv, rv;
        xfer(0, 1'b1, 32'h1C, 32'hDEAD_BEEF, gc, rc, rd, ra, er, rw, gv, rv);
        checks++;
        if (gc !== 1 || rc !== 2 || er !== 1'b1 || rw !== 1'b0) begin
            errors++; $display("FAIL illegal_1c got gc=%0d rc=%0d err=%b rw=%b want 1 2 1 0", gc, rc, er, rw);
        end
        xfer(1, 1'b1, 32'h02, 32'hBAD0_BAD0, gc, rc, rd, ra, er, rw, gv, rv);
        checks++;
        if (gc !== 1 || rc !== 2 || er !== 1'b1 || rw !== 1'b0 || rv !== 2'b10) begin
            errors++; $display("FAIL illegal_02 got gc=%0d rc=%0d err=%b rw=%b rv=%b want 1 2 1 0 10", gc, rc, er, rw, rv);
        end
        xfer(0, 1'b0, 32'h18, 32'h0, gc, rc, rd, ra, er, rw, gv, rv);
        xfer(1, 1'b0, 32'h1C, 32'h0, gc, rc, rd, ra, er, rw, gv, rv);
        checks++;
        if (rc !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL illegal_read got rc=%0d err=%b rd=%h want 2 1 0", rc, er, rd);
        end
        for (int i = 0; i < 7; i++) begin
            xfer(i % 2, 1'b0, 32'(i * 4), 32'h0, gc, rc, rd, ra, er, rw, gv, rv);
            checks++;
            if (rd !== sh[i] || er !== 1'b0) begin
                errors++; $display("FAIL illegal_readback%0d got %h err=%b want %h", i, rd, er, sh[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic seen;
        @(negedge clk);
        req[0] = 1'b1; req_we[0] = 1'b0; req_addr[31:0] = 32'h08;
        @(negedge clk);
        req[0] = 1'b0;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL midreset_gnt got %b want 01", gnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, rf_regwrite, rsp_rdata, rf_addr, rf_write_data} !== '0) begin
            errors++; $display("FAIL midreset_outputs got gnt=%b rv=%b err=%b we=%b rd=%h a=%h wd=%h",
                gnt, rsp_valid, rsp_err, rf_regwrite, rsp_rdata, rf_addr, rf_write_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= |rsp_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL midreset_norsp got rsp_valid pulse want none");
        end
    endtask

    task automatic test_contention;
        logic [1:0]  ex [4], gvs [4], rvs [4];
        logic [31:0] rds [4];
        int          gk [4], rk [4];
        int          ng, nr;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        ex[0] = 2'b01; ex[1] = 2'b01; ex[2] = 2'b01; ex[3] = 2'b01;
`else
        ex[0] = 2'b01; ex[1] = 2'b10; ex[2] = 2'b01; ex[3] = 2'b10;
`endif
        ng = 0; nr = 0;
        @(negedge clk);
        req = 2'b11; req_we = 2'b00; req_addr = {32'h04, 32'h00};
        for (int k = 1; k <= 24 && nr < 4; k++) begin
            @(negedge clk);
            if (gnt != 0 && ng < 4) begin
                gvs[ng] = gnt; gk[ng] = k; ng++;
                if (ng == 4) req = 2'b00;
            end
            if (rsp_valid != 0 && nr < 4) begin rvs[nr] = rsp_valid; rds[nr] = rsp_rdata; rk[nr] = k; nr++; end
        end
        req = 2'b00;
        checks++;
        if (ng !== 4 || nr !== 4) begin
            errors++; $display("FAIL cont_count got gnts=%0d rsps=%0d want 4 4", ng, nr);
        end
        for (int i = 0; i < ng && i < nr; i++) begin
            checks++;
            if (gvs[i] !== ex[i] || rvs[i] !== ex[i] || gk[i] !== 1 + 4 * i || rk[i] !== 3 + 4 * i) begin
                errors++; $display("FAIL cont%0d got gnt=%b@%0d rsp=%b@%0d want %b@%0d %b@%0d",
                    i, gvs[i], gk[i], rvs[i], rk[i], ex[i], 1 + 4 * i, ex[i], 3 + 4 * i);
            end
            checks++;
            if (rds[i] !== (ex[i] == 2'b01 ? sh[0] : sh[1])) begin
                errors++; $display("FAIL cont_data%0d got %h want %h", i, rds[i], ex[i] == 2'b01 ? sh[0] : sh[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_all();
        test_single_write();
        test_single_read();
        test_illegal();
        test_reset_mid_read();
        test_contention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
